// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among byte sources
module uart_tx_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int DATA_WIDTH    = 8,
   parameter int START_TIMEOUT = 4,
   localparam int IDW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int CNTW = $clog2(START_TIMEOUT + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          tx_start,
   output logic [DATA_WIDTH-1:0]         tx_data,
   input  logic                          tx_busy,
   output logic [IDW-1:0]                grant_id,
   output logic                          active,
   output logic                          timeout_err
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [IDW-1:0]          ptr_q, ptr_d;
   logic [CNTW-1:0]         cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
   logic [IDW-1:0]          grant_q, grant_d;
   logic [NUM_REQ-1:0]      req_ready_q, req_ready_d;
   logic                    tx_start_q, tx_start_d;
   logic                    active_q, active_d;
   logic                    timeout_err_q, timeout_err_d;

   logic                    hi_found, lo_found, sel_found;
   logic [IDW-1:0]          hi_idx, lo_idx, sel_idx;
   logic [DATA_WIDTH-1:0]   hi_data, lo_data, sel_data;

   // Rotating priority: lowest set index at or above ptr wins, else lowest set index overall
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      hi_data  = '0;
      lo_data  = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            lo_found = 1'b1;
            lo_idx   = IDW'(i);
            lo_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            if (IDW'(i) >= ptr_q) begin
               hi_found = 1'b1;
               hi_idx   = IDW'(i);
               hi_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
      sel_found = hi_found | lo_found;
      sel_idx   = hi_found ? hi_idx  : lo_idx;
      sel_data  = hi_found ? hi_data : lo_data;
   end

   // Next-state and registered-output logic; outputs are computed one cycle ahead
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      cnt_d         = cnt_q;
      tx_data_d     = tx_data_q;
      grant_d       = grant_q;
      req_ready_d   = '0;
      tx_start_d    = 1'b0;
      timeout_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (sel_found) begin
               tx_data_d            = sel_data;
               grant_d              = sel_idx;
               req_ready_d[sel_idx] = 1'b1;
               tx_start_d           = 1'b1;
               state_d              = START;
            end
         end
         START: begin
            // Winner becomes lowest priority for the next arbitration
            ptr_d   = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
            cnt_d   = '0;
            state_d = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            // The error pulse is already out when the counter hits the limit; leave and drop the byte
            if (cnt_q == CNTW'(START_TIMEOUT)) begin
               state_d = IDLE;
            end else if (tx_busy) begin
               state_d = WAIT_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNTW'(START_TIMEOUT - 1)) begin
                  timeout_err_d = 1'b1;
               end
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      active_d = (state_d != IDLE);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         cnt_q         <= '0;
         tx_data_q     <= '0;
         grant_q       <= '0;
         req_ready_q   <= '0;
         tx_start_q    <= 1'b0;
         active_q      <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         cnt_q         <= cnt_d;
         tx_data_q     <= tx_data_d;
         grant_q       <= grant_d;
         req_ready_q   <= req_ready_d;
         tx_start_q    <= tx_start_d;
         active_q      <= active_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign tx_start    = tx_start_q;
   assign tx_data     = tx_data_q;
   assign grant_id    = grant_q;
   assign active      = active_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int TO = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            tx_start;
   logic [DW-1:0]   tx_data;
   logic            tx_busy;
   logic [1:0]      grant_id;
   logic            active;
   logic            timeout_err;

   int n_vec = 0;
   int n_bad = 0;
   int exp_ptr = 0;

   uart_tx_arbiter #(
      .NUM_REQ(N), .DATA_WIDTH(DW), .START_TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
      .tx_busy(tx_busy), .grant_id(grant_id), .active(active),
      .timeout_err(timeout_err)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Reference arbitration: first set bit scanning upward from the pointer, wrapping
   function automatic int ref_arb(input logic [N-1:0] v);
      for (int k = 0; k < N; k++) begin
         if (v[(exp_ptr + k) % N]) return (exp_ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_tx_start"}, tx_start, 0);
      check_eq({tag, "_req_ready"}, req_ready, 0);
      check_eq({tag, "_tx_data"}, tx_data, 0);
      check_eq({tag, "_grant_id"}, grant_id, 0);
      check_eq({tag, "_active"}, active, 0);
      check_eq({tag, "_timeout_err"}, timeout_err, 0);
   endtask

   task automatic do_reset;
      rst = 1'b1; req_valid = '0; req_data = '0; tx_busy = 1'b0;
      step;
      step;
      check_all_zero("reset");
      rst = 1'b0;
      exp_ptr = 0;
   endtask

   // One transfer, entered in an IDLE cycle. k = cycle after tx_start where busy rises
   // (0 = never, forcing a timeout), len = busy length. Returns in the following IDLE cycle.
   task automatic xfer(input logic [N-1:0] v, input logic [N*DW-1:0] d,
                       input int k, input int len, input bit wiggle);
      int            w;
      int            t_end;
      bit            tmo;
      logic [DW-1:0] ed;
      req_valid = v;
      req_data  = d;
      check_eq("pre_active", active, 0);
      w  = ref_arb(v);
      ed = d[w*DW +: DW];
      step;
      check_eq("tx_start", tx_start, 1);
      check_eq("req_ready", req_ready, 32'd1 << w);
      check_eq("grant_id", grant_id, w);
      check_eq("tx_data", tx_data, ed);
      check_eq("start_active", active, 1);
      check_eq("start_tmo", timeout_err, 0);
      exp_ptr = (w + 1) % N;
      tmo   = (k == 0);
      t_end = tmo ? TO + 2 : k + len + 1;
      tx_busy   = 1'b0;
      req_valid = wiggle ? N'($urandom) : (v & ~(N'(1) << w));
      if (wiggle) req_data = {$urandom};
      for (int t = 1; t <= t_end; t++) begin
         step;
         check_eq("busy_tx_start", tx_start, 0);
         check_eq("busy_req_ready", req_ready, 0);
         check_eq("hold_tx_data", tx_data, ed);
         check_eq("hold_grant", grant_id, w);
         check_eq("active", active, (t < t_end) ? 1 : 0);
         check_eq("timeout_err", timeout_err, (tmo && t == TO + 1) ? 1 : 0);
         tx_busy = !tmo && t >= k && t < k + len;
         if (t == t_end) begin
            req_valid = '0;
         end else if (wiggle) begin
            req_valid = N'($urandom);
            req_data  = {$urandom};
         end
      end
   endtask

   initial begin
      int v, k, len;
      do_reset;

      // single request, busy one cycle after start for 10 cycles
      xfer(4'b0001, 32'h000000A5, 1, 10, 1'b0);

      // round robin with all four requesters held valid
      do_reset;
      for (int i = 0; i < 8; i++) begin
         check_eq("rr_expected_order", ref_arb(4'b1111), i % 4);
         xfer(4'b1111, 32'h13121110, 1 + (i % 3), 2, 1'b0);
      end

      // grant to 2, then only requester 1 pending: wrap and skip
      xfer(4'b0100, 32'h44332211, 1, 2, 1'b0);
      xfer(4'b0010, 32'h44332211, 1, 2, 1'b0);

      // timeout: busy never rises, byte not retried
      xfer(4'b1000, 32'hDEADBEEF, 0, 0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         step;
         check_eq("no_retry_tx_start", tx_start, 0);
         check_eq("no_retry_active", active, 0);
      end

      // changes from other requesters during the frame are ignored
      xfer(4'b0001, 32'h5A5A5A77, 2, 6, 1'b1);

      // reset while in WAIT_DONE
      req_valid = 4'b0100; req_data = 32'h00990000;
      step;
      check_eq("mid_start", tx_start, 1);
      req_valid = '0; tx_busy = 1'b1;
      step;
      step;
      step;
      check_eq("mid_active", active, 1);
      rst = 1'b1;
      step;
      check_all_zero("midreset");
      rst = 1'b0; tx_busy = 1'b0; exp_ptr = 0;
      xfer(4'b1111, 32'hA3A2A1A0, 1, 1, 1'b0);

      // randomized traffic
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            req_valid = '0;
            for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
               step;
               check_eq("gap_active", active, 0);
               check_eq("gap_tx_start", tx_start, 0);
            end
         end
         v   = int'($urandom_range(1, 15));
         k   = int'($urandom_range(0, TO));
         len = int'($urandom_range(1, 6));
         xfer(N'(v), {$urandom}, k, len, 1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
